// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the DDR port arbiter.
// Holds default widths, the port index type and the round-robin picker.
package ddr_arb_pkg;

    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 256;

    typedef logic [2:0] port_idx_t;

    typedef struct packed {
        logic      found;
        port_idx_t idx;
    } rr_pick_t;

    // Candidates above NUM_PORTS are always zero, so a mod-8 walk
    // visits the live ports in the same order as a mod-NUM_PORTS walk.
    function automatic rr_pick_t rr_pick(
        input logic [7:0] valid_vec,
        input port_idx_t  ptr
    );
        rr_pick_t  r;
        port_idx_t i;
        r = '0;
        for (int k = 7; k >= 0; k--) begin
            i = ptr + port_idx_t'(k);
            if (valid_vec[i]) begin
                r.found = 1'b1;
                r.idx   = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// Requester-side bundle of the DDR port arbiter.
// master: requesters drive req_valid/we/addr/wdata; slave: arbiter drives
// req_ready, rsp_valid (one-hot) and the shared rsp_data.
interface ddr_port_arbiter_if
    import ddr_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) ();

    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/ddr_arb_tag_fifo.sv
// Read-tag FIFO: remembers which port owns each read in flight.
// Ports: clk, rst (async active-low), push/push_idx, pop/pop_idx,
// full, empty, count. Push when full and pop when empty are ignored.
module ddr_arb_tag_fifo
    import ddr_arb_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  port_idx_t push_idx,
    input  logic      pop,
    output port_idx_t pop_idx,
    output logic      full,
    output logic      empty,
    output logic [AW:0] count
);

    port_idx_t     mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        full    = (cnt_q == (AW+1)'(DEPTH));
        empty   = (cnt_q == '0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wp_d    = wp_q + AW'(do_push);
        rp_d    = rp_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        pop_idx = mem_q[rp_q];
        count   = cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wp_q] <= push_idx;
            end
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one ddr_ram_control_mig user port among NUM_PORTS requesters.
// Ports: ui_clk, rst (async active-low), req (requester bundle, slave),
// ctl_wr_*/ctl_rd_* controller side, outstanding, err_unexpected.
// Optional DDR_PORT_ARBITER_PERF_EN adds perf_clr, perf_wr_cnt, perf_rd_cnt.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter  int NUM_PORTS       = 4,
    parameter  int ADDR_W          = ADDR_W_DEF,
    parameter  int DATA_W          = DATA_W_DEF,
    parameter  int MAX_OUTSTANDING = 16,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic              ui_clk,
    input  logic              rst,
    ddr_port_arbiter_if.slave req,
    output logic              ctl_wr_en,
    output logic [ADDR_W-1:0] ctl_wr_addr,
    output logic [DATA_W-1:0] ctl_wr_data,
    input  logic              ctl_wr_busy,
    output logic              ctl_rd_en,
    output logic [ADDR_W-1:0] ctl_rd_addr,
    input  logic              ctl_rd_busy,
    input  logic [DATA_W-1:0] ctl_rd_data,
    input  logic              ctl_rd_data_valid,
    output logic [CNT_W-1:0]  outstanding,
    output logic              err_unexpected
`ifdef DDR_PORT_ARBITER_PERF_EN
    ,
    input  logic                    perf_clr,
    output logic [NUM_PORTS*32-1:0] perf_wr_cnt,
    output logic [NUM_PORTS*32-1:0] perf_rd_cnt
`endif
);

    port_idx_t wr_ptr_q, wr_ptr_d;
    port_idx_t rd_ptr_q, rd_ptr_d;
    logic [7:0] wr_cand, rd_cand;
    rr_pick_t   wr_pick, rd_pick;
    logic       wr_go, rd_go;
    logic [7:0] ready_oh, rsp_oh;

    logic       fifo_full, fifo_empty, fifo_pop;
    port_idx_t  fifo_tag;

    logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 err_q, err_d;

    function automatic port_idx_t ptr_next(input port_idx_t w);
        return (int'(w) == NUM_PORTS - 1) ? '0 : w + 3'd1;
    endfunction

    // Grants are gated by rst so nothing issues while reset is held.
    always_comb begin
        wr_cand  = 8'(req.req_valid & req.req_we);
        rd_cand  = 8'(req.req_valid & ~req.req_we);
        wr_pick  = rr_pick(wr_cand, wr_ptr_q);
        rd_pick  = rr_pick(rd_cand, rd_ptr_q);
        wr_go    = wr_pick.found & ~ctl_wr_busy & rst;
        rd_go    = rd_pick.found & ~ctl_rd_busy & ~fifo_full & rst;
        wr_ptr_d = wr_go ? ptr_next(wr_pick.idx) : wr_ptr_q;
        rd_ptr_d = rd_go ? ptr_next(rd_pick.idx) : rd_ptr_q;

        ready_oh = '0;
        if (wr_go) begin
            ready_oh[wr_pick.idx] = 1'b1;
        end
        if (rd_go) begin
            ready_oh[rd_pick.idx] = 1'b1;
        end
        req.req_ready = ready_oh[NUM_PORTS-1:0];

        ctl_wr_en   = wr_go;
        ctl_wr_addr = req.req_addr[int'(wr_pick.idx)*ADDR_W +: ADDR_W];
        ctl_wr_data = req.req_wdata[int'(wr_pick.idx)*DATA_W +: DATA_W];
        ctl_rd_en   = rd_go;
        ctl_rd_addr = req.req_addr[int'(rd_pick.idx)*ADDR_W +: ADDR_W];
    end

    ddr_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (ui_clk),
        .rst      (rst),
        .push     (rd_go),
        .push_idx (rd_pick.idx),
        .pop      (fifo_pop),
        .pop_idx  (fifo_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (outstanding)
    );

    // Data arriving with no tag has no owner: drop it and flag.
    always_comb begin
        fifo_pop = ctl_rd_data_valid & ~fifo_empty;
        rsp_oh   = '0;
        if (fifo_pop) begin
            rsp_oh[fifo_tag] = 1'b1;
        end
        rsp_valid_d = rsp_oh[NUM_PORTS-1:0];
        rsp_data_d  = fifo_pop ? ctl_rd_data : rsp_data_q;
        err_d       = err_q | (ctl_rd_data_valid & fifo_empty);
    end

    always_ff @(posedge ui_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign req.rsp_valid  = rsp_valid_q;
    assign req.rsp_data   = rsp_data_q;
    assign err_unexpected = err_q;

`ifdef DDR_PORT_ARBITER_PERF_EN
    logic [31:0] perf_wr_q [NUM_PORTS];
    logic [31:0] perf_wr_d [NUM_PORTS];
    logic [31:0] perf_rd_q [NUM_PORTS];
    logic [31:0] perf_rd_d [NUM_PORTS];

    // Clear beats increment; counters stick at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            perf_wr_d[i] = perf_wr_q[i];
            perf_rd_d[i] = perf_rd_q[i];
            if (perf_clr) begin
                perf_wr_d[i] = '0;
                perf_rd_d[i] = '0;
            end else begin
                if (wr_go && wr_pick.idx == port_idx_t'(i)
                    && perf_wr_q[i] != 32'hFFFF_FFFF) begin
                    perf_wr_d[i] = perf_wr_q[i] + 32'd1;
                end
                if (rd_go && rd_pick.idx == port_idx_t'(i)
                    && perf_rd_q[i] != 32'hFFFF_FFFF) begin
                    perf_rd_d[i] = perf_rd_q[i] + 32'd1;
                end
            end
            perf_wr_cnt[i*32 +: 32] = perf_wr_q[i];
            perf_rd_cnt[i*32 +: 32] = perf_rd_q[i];
        end
    end

    always_ff @(posedge ui_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                perf_wr_q[i] <= '0;
                perf_rd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                perf_wr_q[i] <= perf_wr_d[i];
                perf_rd_q[i] <= perf_rd_d[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter.
// Directed scenarios plus random traffic against a queue-based model.
module tb_ddr_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 25;
    localparam int DW = 256;
    localparam int MO = 16;

    logic          ui_clk = 1'b0;
    logic          rst    = 1'b1;
    logic          ctl_wr_en, ctl_rd_en;
    logic [AW-1:0] ctl_wr_addr, ctl_rd_addr;
    logic [DW-1:0] ctl_wr_data;
    logic          ctl_wr_busy = 1'b0;
    logic          ctl_rd_busy = 1'b0;
    logic [DW-1:0] ctl_rd_data = '0;
    logic          ctl_rd_data_valid = 1'b0;
    logic [4:0]    outstanding;
    logic          err_unexpected;
`ifdef DDR_PORT_ARBITER_PERF_EN
    logic          perf_clr = 1'b0;
    logic [N*32-1:0] perf_wr_cnt, perf_rd_cnt;
`endif

    ddr_port_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ddr_port_arbiter #(
        .NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .ui_clk            (ui_clk),
        .rst               (rst),
        .req               (bus),
        .ctl_wr_en         (ctl_wr_en),
        .ctl_wr_addr       (ctl_wr_addr),
        .ctl_wr_data       (ctl_wr_data),
        .ctl_wr_busy       (ctl_wr_busy),
        .ctl_rd_en         (ctl_rd_en),
        .ctl_rd_addr       (ctl_rd_addr),
        .ctl_rd_busy       (ctl_rd_busy),
        .ctl_rd_data       (ctl_rd_data),
        .ctl_rd_data_valid (ctl_rd_data_valid),
        .outstanding       (outstanding),
        .err_unexpected    (err_unexpected)
`ifdef DDR_PORT_ARBITER_PERF_EN
        ,
        .perf_clr          (perf_clr),
        .perf_wr_cnt       (perf_wr_cnt),
        .perf_rd_cnt       (perf_rd_cnt)
`endif
    );

    always #5 ui_clk = ~ui_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            m_wr_ptr, m_rd_ptr;
    int            m_tags[$];
    bit            m_err;
    logic [N-1:0]  m_rsp_valid;
    logic [DW-1:0] m_rsp_data;
    int            exp_wr, exp_rd;
    logic [N-1:0]  exp_ready;

    function automatic logic [DW-1:0] rand_d();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] rand_a();
        return AW'($urandom);
    endfunction

    // First requesting port at or after ptr, walking round the ring.
    function automatic int rr_ref(input logic [N-1:0] cand, input int ptr);
        for (int k = 0; k < N; k++)
            if (cand[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int p, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[p] = 1'b1;
        bus.req_we[p]    = we;
        bus.req_addr[p*AW +: AW]  = a;
        bus.req_wdata[p*DW +: DW] = d;
    endtask

    task automatic clr_req(input int p);
        bus.req_valid[p] = 1'b0;
    endtask

    task automatic idle();
        bus.req_valid     = '0;
        ctl_wr_busy       = 1'b0;
        ctl_rd_busy       = 1'b0;
        ctl_rd_data_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_wr_ptr = 0;
        m_rd_ptr = 0;
        m_tags.delete();
        m_err = 1'b0;
        m_rsp_valid = '0;
        m_rsp_data = '0;
    endtask

    task automatic calc();
        logic [N-1:0] wc, rc;
        wc = bus.req_valid & bus.req_we;
        rc = bus.req_valid & ~bus.req_we;
        exp_wr = ctl_wr_busy ? -1 : rr_ref(wc, m_wr_ptr);
        exp_rd = (ctl_rd_busy || m_tags.size() >= MO) ? -1 : rr_ref(rc, m_rd_ptr);
        exp_ready = '0;
        if (exp_wr >= 0) exp_ready[exp_wr] = 1'b1;
        if (exp_rd >= 0) exp_ready[exp_rd] = 1'b1;
    endtask

    // Commit one clock of the model, then advance to posedge+1.
    task automatic tick();
        calc();
        if (exp_wr >= 0) m_wr_ptr = (exp_wr + 1) % N;
        if (exp_rd >= 0) m_rd_ptr = (exp_rd + 1) % N;
        m_rsp_valid = '0;
        if (ctl_rd_data_valid) begin
            if (m_tags.size() > 0) begin
                m_rsp_valid[m_tags.pop_front()] = 1'b1;
                m_rsp_data = ctl_rd_data;
            end else begin
                m_err = 1'b1;
            end
        end
        if (exp_rd >= 0) m_tags.push_back(exp_rd);
        @(posedge ui_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        model_reset();
        @(posedge ui_clk); #1;
        rst = 1'b1;
        @(posedge ui_clk); #1;
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_we = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        #2;
        rst = 1'b0;
        model_reset();
        bus.req_valid = '1;
        bus.req_we = 4'b0011;
        #1;
        n_tests++; if (bus.req_ready !== 4'b0) begin n_fail++;
            $display("FAIL rst_ready got %b want 0000", bus.req_ready); end
        n_tests++; if (ctl_wr_en !== 1'b0 || ctl_rd_en !== 1'b0) begin n_fail++;
            $display("FAIL rst_en got wr=%b rd=%b want 0 0", ctl_wr_en, ctl_rd_en); end
        n_tests++; if (outstanding !== 5'd0) begin n_fail++;
            $display("FAIL rst_outstanding got %0d want 0", outstanding); end
        n_tests++; if (err_unexpected !== 1'b0 || bus.rsp_valid !== 4'b0) begin n_fail++;
            $display("FAIL rst_rsp got err=%b rsp=%b want 0", err_unexpected, bus.rsp_valid); end
        idle();
        @(posedge ui_clk); #1;
        rst = 1'b1;
        @(posedge ui_clk); #1;
    endtask

    task automatic test_write_fairness();
        idle();
        for (int p = 0; p < N; p++) set_req(p, 1'b1, rand_a(), rand_d());
        for (int c = 0; c < 2 * N; c++) begin
            #1; calc();
            n_tests++; if (ctl_wr_en !== 1'b1 || bus.req_ready !== 4'(1 << (c % N))) begin
                n_fail++;
                $display("FAIL wr_fair_grant c=%0d got en=%b ready=%b want 1 %b",
                         c, ctl_wr_en, bus.req_ready, 4'(1 << (c % N)));
            end
            n_tests++; if (ctl_wr_addr !== bus.req_addr[(c % N)*AW +: AW]
                           || ctl_wr_data !== bus.req_wdata[(c % N)*DW +: DW]) begin
                n_fail++;
                $display("FAIL wr_fair_payload c=%0d got %h want %h",
                         c, ctl_wr_addr, bus.req_addr[(c % N)*AW +: AW]);
            end
            tick();
            set_req(c % N, 1'b1, rand_a(), rand_d());
        end
        idle();
        tick();
    endtask

    task automatic test_busy_stall();
        idle();
        set_req(1, 1'b1, rand_a(), rand_d());
        set_req(3, 1'b1, rand_a(), rand_d());
        ctl_wr_busy = 1'b1;
        repeat (5) begin
            #1;
            n_tests++; if (bus.req_ready !== 4'b0 || ctl_wr_en !== 1'b0) begin n_fail++;
                $display("FAIL busy_stall got ready=%b en=%b want 0000 0",
                         bus.req_ready, ctl_wr_en); end
            tick();
        end
        ctl_wr_busy = 1'b0;
        #1;
        n_tests++; if (bus.req_ready !== 4'b0010 || ctl_wr_addr !== bus.req_addr[1*AW +: AW]) begin
            n_fail++;
            $display("FAIL busy_release1 got ready=%b want 0010", bus.req_ready); end
        tick();
        clr_req(1);
        #1;
        n_tests++; if (bus.req_ready !== 4'b1000 || ctl_wr_en !== 1'b1) begin n_fail++;
            $display("FAIL busy_release3 got ready=%b want 1000", bus.req_ready); end
        tick();
        idle();
    endtask

    task automatic test_read_routing();
        logic [DW-1:0] d1, d2, d3;
        d1 = rand_d();
        d2 = rand_d();
        d3 = rand_d();
        idle();
        set_req(2, 1'b0, 25'h10, '0);
        #1;
        n_tests++; if (ctl_rd_en !== 1'b1 || ctl_rd_addr !== 25'h10 || bus.req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL rd_issue2 got en=%b addr=%h ready=%b want 1 10 0100",
                     ctl_rd_en, ctl_rd_addr, bus.req_ready); end
        tick(); clr_req(2);
        set_req(0, 1'b0, 25'h20, '0);
        #1;
        n_tests++; if (ctl_rd_addr !== 25'h20 || bus.req_ready !== 4'b0001) begin n_fail++;
            $display("FAIL rd_issue0 got addr=%h ready=%b want 20 0001",
                     ctl_rd_addr, bus.req_ready); end
        tick(); clr_req(0);
        n_tests++; if (outstanding !== 5'd2) begin n_fail++;
            $display("FAIL rd_outstanding got %0d want 2", outstanding); end
        ctl_rd_data = d1; ctl_rd_data_valid = 1'b1;
        tick();
        ctl_rd_data = d2;
        n_tests++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== d1) begin n_fail++;
            $display("FAIL rd_route_d1 got %b %h want 0100 %h", bus.rsp_valid, bus.rsp_data, d1); end
        tick();
        ctl_rd_data_valid = 1'b0; ctl_rd_data = rand_d();
        n_tests++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== d2) begin n_fail++;
            $display("FAIL rd_route_d2 got %b %h want 0001 %h", bus.rsp_valid, bus.rsp_data, d2); end
        tick();
        n_tests++; if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== d2 || outstanding !== 5'd0) begin
            n_fail++;
            $display("FAIL rd_hold got %b %h out=%0d want 0000 %h 0",
                     bus.rsp_valid, bus.rsp_data, outstanding, d2); end
        // push and pop in the same cycle
        set_req(3, 1'b0, rand_a(), '0);
        tick(); clr_req(3);
        set_req(1, 1'b0, rand_a(), '0);
        ctl_rd_data = d3; ctl_rd_data_valid = 1'b1;
        tick(); clr_req(1); ctl_rd_data_valid = 1'b0;
        n_tests++; if (outstanding !== 5'd1 || bus.rsp_valid !== 4'b1000) begin n_fail++;
            $display("FAIL rd_pushpop got out=%0d rsp=%b want 1 1000", outstanding, bus.rsp_valid); end
        ctl_rd_data_valid = 1'b1;
        tick(); ctl_rd_data_valid = 1'b0;
        n_tests++; if (bus.rsp_valid !== 4'b0010 || outstanding !== 5'd0) begin n_fail++;
            $display("FAIL rd_last got rsp=%b out=%0d want 0010 0", bus.rsp_valid, outstanding); end
    endtask

    task automatic test_fifo_full();
        int p;
        idle();
        for (int i = 0; i < MO; i++) begin
            p = int'($urandom_range(0, N - 1));
            set_req(p, 1'b0, rand_a(), '0);
            #1;
            n_tests++; if (ctl_rd_en !== 1'b1 || bus.req_ready !== 4'(1 << p)
                           || ctl_rd_addr !== bus.req_addr[p*AW +: AW]) begin n_fail++;
                $display("FAIL fill_issue i=%0d got en=%b ready=%b want 1 %b",
                         i, ctl_rd_en, bus.req_ready, 4'(1 << p)); end
            tick(); clr_req(p);
        end
        n_tests++; if (outstanding !== 5'd16) begin n_fail++;
            $display("FAIL full_count got %0d want 16", outstanding); end
        set_req(0, 1'b0, rand_a(), '0);
        set_req(1, 1'b1, rand_a(), rand_d());
        #1;
        n_tests++; if (ctl_rd_en !== 1'b0 || bus.req_ready[0] !== 1'b0) begin n_fail++;
            $display("FAIL full_block got en=%b ready=%b want 0", ctl_rd_en, bus.req_ready); end
        n_tests++; if (ctl_wr_en !== 1'b1 || bus.req_ready[1] !== 1'b1
                       || ctl_wr_addr !== bus.req_addr[1*AW +: AW]) begin n_fail++;
            $display("FAIL full_wr got en=%b ready=%b want 1 xx1x", ctl_wr_en, bus.req_ready); end
        tick(); clr_req(1);
        ctl_rd_data_valid = 1'b1; ctl_rd_data = rand_d();
        tick(); ctl_rd_data_valid = 1'b0;
        n_tests++; if (ctl_rd_en !== 1'b1 || bus.rsp_valid !== m_rsp_valid) begin n_fail++;
            $display("FAIL full_reissue got en=%b rsp=%b want 1 %b",
                     ctl_rd_en, bus.rsp_valid, m_rsp_valid); end
        tick(); clr_req(0);
        n_tests++; if (outstanding !== 5'd16) begin n_fail++;
            $display("FAIL full_steady got %0d want 16", outstanding); end
        ctl_rd_data_valid = 1'b1;
        for (int i = 0; i < MO; i++) begin
            ctl_rd_data = rand_d();
            tick();
            n_tests++; if (bus.rsp_valid !== m_rsp_valid || bus.rsp_data !== m_rsp_data) begin
                n_fail++;
                $display("FAIL drain i=%0d got %b want %b", i, bus.rsp_valid, m_rsp_valid); end
        end
        ctl_rd_data_valid = 1'b0;
        tick();
        n_tests++; if (outstanding !== 5'd0) begin n_fail++;
            $display("FAIL drain_empty got %0d want 0", outstanding); end
    endtask

    task automatic test_unexpected();
        idle();
        ctl_rd_data_valid = 1'b1; ctl_rd_data = rand_d();
        tick(); ctl_rd_data_valid = 1'b0;
        n_tests++; if (err_unexpected !== 1'b1 || bus.rsp_valid !== 4'b0) begin n_fail++;
            $display("FAIL unexp got err=%b rsp=%b want 1 0000", err_unexpected, bus.rsp_valid); end
        repeat (3) tick();
        n_tests++; if (err_unexpected !== 1'b1) begin n_fail++;
            $display("FAIL unexp_sticky got %b want 1", err_unexpected); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_req(2, 1'b0, rand_a(), '0);
        set_req(1, 1'b1, rand_a(), rand_d());
        tick(); idle();
        set_req(3, 1'b0, rand_a(), '0);
        tick(); idle();
        set_req(2, 1'b0, rand_a(), '0);
        tick(); idle();
        n_tests++; if (outstanding !== 5'd3) begin n_fail++;
            $display("FAIL mid_pre got %0d want 3", outstanding); end
        set_req(0, 1'b1, rand_a(), rand_d());
        set_req(2, 1'b1, rand_a(), rand_d());
        set_req(1, 1'b0, rand_a(), '0);
        set_req(3, 1'b0, rand_a(), '0);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++; if (outstanding !== 5'd0 || ctl_wr_en !== 1'b0 || ctl_rd_en !== 1'b0
                       || bus.req_ready !== 4'b0) begin n_fail++;
            $display("FAIL mid_rst got out=%0d wr=%b rd=%b ready=%b want 0",
                     outstanding, ctl_wr_en, ctl_rd_en, bus.req_ready); end
        bus.req_valid = '0;
        @(posedge ui_clk); #1;
        rst = 1'b1;
        ctl_rd_data_valid = 1'b1; ctl_rd_data = rand_d();
        tick(); ctl_rd_data_valid = 1'b0;
        n_tests++; if (err_unexpected !== 1'b1 || bus.rsp_valid !== 4'b0) begin n_fail++;
            $display("FAIL mid_late got err=%b rsp=%b want 1 0000", err_unexpected, bus.rsp_valid); end
        set_req(0, 1'b1, rand_a(), rand_d());
        set_req(2, 1'b1, rand_a(), rand_d());
        set_req(1, 1'b0, rand_a(), '0);
        set_req(3, 1'b0, rand_a(), '0);
        #1;
        n_tests++; if (bus.req_ready !== 4'b0011) begin n_fail++;
            $display("FAIL mid_ptrs got ready=%b want 0011", bus.req_ready); end
        tick(); idle();
        ctl_rd_data_valid = 1'b1;
        tick(); ctl_rd_data_valid = 1'b0;
        n_tests++; if (bus.rsp_valid !== 4'b0010) begin n_fail++;
            $display("FAIL mid_route got %b want 0010", bus.rsp_valid); end
    endtask

    task automatic test_random();
        int budget;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++)
                if (!bus.req_valid[p] && $urandom_range(0, 1) == 1)
                    set_req(p, 1'($urandom), rand_a(), rand_d());
            ctl_wr_busy = ($urandom_range(0, 3) == 0);
            ctl_rd_busy = ($urandom_range(0, 3) == 0);
            ctl_rd_data_valid = (m_tags.size() > 0) && ($urandom_range(0, 2) == 0);
            ctl_rd_data = rand_d();
            #1; calc();
            n_tests++; if (bus.req_ready !== exp_ready || ctl_wr_en !== (exp_wr >= 0)
                           || ctl_rd_en !== (exp_rd >= 0)) begin n_fail++;
                $display("FAIL rnd_grant c=%0d got ready=%b wr=%b rd=%b want %b",
                         c, bus.req_ready, ctl_wr_en, ctl_rd_en, exp_ready); end
            if (exp_wr >= 0) begin
                n_tests++; if (ctl_wr_addr !== bus.req_addr[exp_wr*AW +: AW]
                               || ctl_wr_data !== bus.req_wdata[exp_wr*DW +: DW]) begin
                    n_fail++;
                    $display("FAIL rnd_wr_payload c=%0d got %h want %h",
                             c, ctl_wr_addr, bus.req_addr[exp_wr*AW +: AW]); end
            end
            if (exp_rd >= 0) begin
                n_tests++; if (ctl_rd_addr !== bus.req_addr[exp_rd*AW +: AW]) begin n_fail++;
                    $display("FAIL rnd_rd_addr c=%0d got %h want %h",
                             c, ctl_rd_addr, bus.req_addr[exp_rd*AW +: AW]); end
            end
            n_tests++; if (bus.rsp_valid !== m_rsp_valid
                           || (m_rsp_valid != '0 && bus.rsp_data !== m_rsp_data)) begin
                n_fail++;
                $display("FAIL rnd_rsp c=%0d got %b want %b", c, bus.rsp_valid, m_rsp_valid); end
            n_tests++; if (outstanding !== 5'(m_tags.size()) || err_unexpected !== m_err) begin
                n_fail++;
                $display("FAIL rnd_state c=%0d got out=%0d err=%b want %0d %b",
                         c, outstanding, err_unexpected, m_tags.size(), m_err); end
            tick();
            if (exp_wr >= 0) clr_req(exp_wr);
            if (exp_rd >= 0) clr_req(exp_rd);
        end
        idle();
        budget = 40;
        while (m_tags.size() > 0 && budget > 0) begin
            ctl_rd_data_valid = 1'b1;
            ctl_rd_data = rand_d();
            tick();
            budget--;
            n_tests++; if (bus.rsp_valid !== m_rsp_valid || bus.rsp_data !== m_rsp_data) begin
                n_fail++;
                $display("FAIL rnd_drain got %b want %b", bus.rsp_valid, m_rsp_valid); end
        end
        ctl_rd_data_valid = 1'b0;
        tick();
        n_tests++; if (outstanding !== 5'd0 || err_unexpected !== 1'b0) begin n_fail++;
            $display("FAIL rnd_end got out=%0d err=%b want 0 0", outstanding, err_unexpected); end
    endtask

    initial begin
        test_reset();
        test_write_fairness();
        test_busy_stall();
        test_read_routing();
        test_fifo_full();
        test_unexpected();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
